regfile_wb_sched: RTL and testbench
===================================

Name: regfile_wb_sched

Overview:
- Write-back scheduler and scoreboard for the 32x32 integer register file.
- Shares the register file's single write port between the ALU and load/store (LSU) write-back sources using round-robin arbitration with valid/ready handshakes.
- Drives the register file write port (RegWrite, WriteRegister, WriteData) from registered outputs.
- Keeps a per-register busy scoreboard and stalls issue on RAW and WAW hazards.

Parameters:
- XLEN, 32, data width of register contents.
- NREG, 32, number of architectural registers; x0 is hardwired zero.
- AW, 5, register index width, equal to log2(NREG).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode presents an instruction.
- issue_rd  in  AW  destination register.
- issue_rs1  in  AW  source 1 index.
- issue_rs2  in  AW  source 2 index.
- issue_use_rs1  in  1  instruction reads rs1.
- issue_use_rs2  in  1  instruction reads rs2.
- issue_stall  out  1  hazard; decode must hold.
- alu_valid  in  1  ALU result pending.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  AW  ALU destination.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  load data pending.
- lsu_ready  out  1  load data accepted this cycle.
- lsu_rd  in  AW  load destination.
- lsu_data  in  XLEN  load data.
- RegWrite  out  1  register file write enable.
- WriteRegister  out  AW  register file write index.
- WriteData  out  XLEN  register file write data.
- busy_mask  out  NREG  scoreboard state (debug/verification).

Behaviour:
- Reset: rst low asynchronously clears busy_mask=0, RegWrite=0, WriteRegister=0, WriteData=0, last_grant=LSU. alu_ready and lsu_ready are forced to 0 while rst is low.
- Scoreboard, bit 0: busy[0] is constant 0.
- issue_stall (combinational) = issue_valid & ((use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2]) | (rd!=0 & busy[rd])).
- Busy set: at the edge where issue_valid & !issue_stall & rd!=0, busy[rd] <= 1.
- Busy clear: at every edge where RegWrite=1, busy[WriteRegister] <= 0. This is the same edge at which the register file captures the data, so an issue in the following cycle reads the new value combinationally. No bypass path exists.
- Set and clear of the same index on the same edge cannot occur: the WAW stall prevents it. Set has priority, defensively.
- Arbitration (combinational):
  - One valid source: it is granted.
  - Both valid: the source other than last_grant is granted.
  - ready = grant. A transfer is valid & ready.
  - last_grant updates only on a transfer.
  - A source whose valid stays high must hold rd and data stable until ready.
- Write port: at the transfer edge, WriteRegister <= rd, WriteData <= data, RegWrite <= (rd!=0). With no transfer, RegWrite <= 0 and WriteRegister/WriteData hold.
- Latency: transfer at edge N; register file written and busy cleared at edge N+1.
- Write-back to rd=0: the handshake completes, RegWrite stays 0, the scoreboard is untouched.
- Write-back to a non-busy register: legal; the write occurs and busy stays 0.
- Throughput: one write-back per cycle. The losing source waits at least one cycle.
- Reset mid-operation: all in-flight state is discarded, including a pending RegWrite. Requesters must re-present after reset.

Decomposition:
- Shared package rv_regfile_pkg holds:
  - XLEN, NREG, AW constants.
  - typedef reg_idx_t (logic [AW-1:0]) and xlen_t (logic [XLEN-1:0]).
  - enum wb_src_t {WB_ALU, WB_LSU}.
- One natural sub-module: wb_rr_arbiter, a 2-way round-robin arbiter holding last_grant, with inputs req[1:0] and transfer, and output gnt[1:0].

Test Plan:
- Reset: drive rst low mid-cycle with busy_mask=0x200 and RegWrite=1. Without waiting for a clock edge, busy_mask=0, RegWrite=0, alu_ready=lsu_ready=0.
- RAW, x5:
  - Issue rd=5; next cycle busy_mask=0x20.
  - Issue use_rs1, rs1=5; issue_stall=1.
  - ALU presents rd=5, data 0xDEADBEEF, with alu_ready=1.
  - Next cycle: RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF.
  - Following cycle: busy[5]=0, issue_stall=0.
- Conflict / round-robin:
  - ALU (rd=3, 0x11) and LSU (rd=4, 0x22) valid together after reset: ALU is written first, LSU the next cycle.
  - A second simultaneous pair is granted LSU first.
- x0:
  - Issue rd=0: busy_mask unchanged, no stall.
  - LSU write-back with rd=0, data 0xFFFFFFFF: lsu_ready=1, RegWrite stays 0.
- WAW, x7: with busy[7]=1, issue rd=7 gives issue_stall=1 until the write-back commits; then busy[7] is re-set on the issuing edge.
- Back-to-back:
  - Stream: ALU valid 4 consecutive cycles, rd=1..4.
  - Response: RegWrite high 4 consecutive cycles, WriteRegister=1,2,3,4 in order.
  - Busy bits clear one per cycle.

Source files
------------

// File: rtl/rv_regfile_pkg.sv
// Shared types and sizes for the integer register file and its write-back scheduler.
package rv_regfile_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] xlen_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_t;
endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter: on contention the source that did not win last is granted.
module wb_rr_arbiter
    import rv_regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       transfer,
    output logic [1:0] gnt
);
    wb_src_t last_grant_q, last_grant_d;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant_q == WB_LSU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (transfer) begin
            last_grant_d = gnt[1] ? WB_LSU : WB_ALU;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= WB_LSU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: arbitrates ALU/LSU onto the register file write port and
// tracks per-register busy bits so decode stalls on RAW and WAW hazards.
module regfile_wb_sched
    import rv_regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    input  logic            issue_use_rs1,
    input  logic            issue_use_rs2,
    output logic            issue_stall,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            RegWrite,
    output logic [AW-1:0]   WriteRegister,
    output logic [XLEN-1:0] WriteData,
    output logic [NREG-1:0] busy_mask
);
    logic [NREG-1:0] busy_q, busy_d;
    logic            reg_write_q, reg_write_d;
    reg_idx_t        wr_idx_q, wr_idx_d;
    xlen_t           wr_data_q, wr_data_d;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       transfer;
    logic       issue_fire;

    assign req      = {lsu_valid, alu_valid};
    assign transfer = |(req & gnt);

    wb_rr_arbiter u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .transfer (transfer),
        .gnt      (gnt)
    );

    // Flops are frozen while rst is low, so only the visible handshake needs masking.
    assign alu_ready = gnt[0] & rst;
    assign lsu_ready = gnt[1] & rst;

    assign issue_stall = issue_valid &
                         ((issue_use_rs1 & busy_q[issue_rs1]) |
                          (issue_use_rs2 & busy_q[issue_rs2]) |
                          ((issue_rd != '0) & busy_q[issue_rd]));

    assign issue_fire = issue_valid & ~issue_stall & (issue_rd != '0);

    // Set wins over clear; the WAW stall normally keeps them apart anyway.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_d[gi] = 1'b0;
            end else begin : g_reg
                assign busy_d[gi] = (issue_fire && issue_rd == reg_idx_t'(gi)) ? 1'b1 :
                                    (reg_write_q && wr_idx_q == reg_idx_t'(gi)) ? 1'b0 :
                                    busy_q[gi];
            end
        end
    endgenerate

    always_comb begin
        reg_write_d = 1'b0;
        wr_idx_d    = wr_idx_q;
        wr_data_d   = wr_data_q;
        if (transfer) begin
            wr_idx_d    = gnt[1] ? lsu_rd   : alu_rd;
            wr_data_d   = gnt[1] ? lsu_data : alu_data;
            reg_write_d = (wr_idx_d != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q      <= '0;
            reg_write_q <= 1'b0;
            wr_idx_q    <= '0;
            wr_data_q   <= '0;
        end else begin
            busy_q      <= busy_d;
            reg_write_q <= reg_write_d;
            wr_idx_q    <= wr_idx_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign RegWrite      = reg_write_q;
    assign WriteRegister = wr_idx_q;
    assign WriteData     = wr_data_q;
    assign busy_mask     = busy_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: stall vector table, directed hazard/arbitration
// sequences, then randomized traffic against a transaction-level scoreboard model.
module tb_regfile_wb_sched;
    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_use_rs1, issue_use_rs2;
    logic        issue_stall;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [31:0] busy_mask;

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_wb_sched dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_stall   (issue_stall),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_rd        (lsu_rd),
        .lsu_data      (lsu_data),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .busy_mask     (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       exp_stall;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        issue_use_rs1 = 0; issue_use_rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Scoreboard model state for the random phase
    bit          busy_m [32];
    bit          last_lsu;
    bit          pv;
    int          prd;
    logic [31:0] pdata;

    initial begin
        bit e_stall, e_ag, e_lg, a_x, l_x;
        logic [31:0] e_busy;

        // ---------------- reset state ----------------
        idle_inputs();
        rst = 1'b0;
        #2;
        chk("reset_busy", busy_mask, 32'h0);
        chk("reset_regwrite", {31'b0, RegWrite}, 32'h0);
        chk("reset_wreg", {27'b0, WriteRegister}, 32'h0);
        chk("reset_wdata", WriteData, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // async reset mid-cycle with busy[9] set and a write pending
        issue_valid = 1; issue_rd = 9;
        tick();
        issue_valid = 0;
        chk("rst_pre_busy", busy_mask, 32'h200);
        alu_valid = 1; alu_rd = 9; alu_data = 32'hCAFE0009;
        tick();
        chk("rst_pre_regwrite", {31'b0, RegWrite}, 32'h1);
        chk("rst_pre_busy2", busy_mask, 32'h200);
        lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h3;
        #2 rst = 1'b0;
        #1;
        chk("rst_async_busy", busy_mask, 32'h0);
        chk("rst_async_regwrite", {31'b0, RegWrite}, 32'h0);
        chk("rst_async_alu_ready", {31'b0, alu_ready}, 32'h0);
        chk("rst_async_lsu_ready", {31'b0, lsu_ready}, 32'h0);
        idle_inputs();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_after_regwrite", {31'b0, RegWrite}, 32'h0);
        chk("rst_after_busy", busy_mask, 32'h0);

        // ---------------- stall table ----------------
        vecs[0] = '{v:1'b0, rd:5'd2, rs1:5'd2, rs2:5'd6, u1:1'b1, u2:1'b1, exp_stall:1'b0};
        vecs[1] = '{v:1'b1, rd:5'd1, rs1:5'd2, rs2:5'd3, u1:1'b0, u2:1'b1, exp_stall:1'b0};
        vecs[2] = '{v:1'b1, rd:5'd1, rs1:5'd2, rs2:5'd3, u1:1'b1, u2:1'b0, exp_stall:1'b1};
        vecs[3] = '{v:1'b1, rd:5'd1, rs1:5'd0, rs2:5'd6, u1:1'b0, u2:1'b1, exp_stall:1'b1};
        vecs[4] = '{v:1'b1, rd:5'd2, rs1:5'd0, rs2:5'd0, u1:1'b0, u2:1'b0, exp_stall:1'b1};
        vecs[5] = '{v:1'b1, rd:5'd0, rs1:5'd0, rs2:5'd0, u1:1'b1, u2:1'b1, exp_stall:1'b0};
        vecs[6] = '{v:1'b1, rd:5'd6, rs1:5'd1, rs2:5'd1, u1:1'b0, u2:1'b0, exp_stall:1'b1};
        vecs[7] = '{v:1'b1, rd:5'd3, rs1:5'd3, rs2:5'd4, u1:1'b1, u2:1'b1, exp_stall:1'b0};
        vecs[8] = '{v:1'b1, rd:5'd0, rs1:5'd6, rs2:5'd2, u1:1'b0, u2:1'b1, exp_stall:1'b1};

        do_reset();
        issue_valid = 1; issue_rd = 2;
        tick();
        issue_rd = 6;
        tick();
        issue_valid = 0;
        chk("table_setup_busy", busy_mask, 32'h44);
        for (int i = 0; i < 9; i++) begin
            issue_valid = vecs[i].v; issue_rd = vecs[i].rd;
            issue_rs1 = vecs[i].rs1; issue_rs2 = vecs[i].rs2;
            issue_use_rs1 = vecs[i].u1; issue_use_rs2 = vecs[i].u2;
            #1;
            chk($sformatf("table_stall[%0d]", i), {31'b0, issue_stall}, {31'b0, vecs[i].exp_stall});
            issue_valid = 0;
            tick();
        end

        // ---------------- RAW on x5 ----------------
        do_reset();
        issue_valid = 1; issue_rd = 5;
        #1 chk("raw_first_issue_stall", {31'b0, issue_stall}, 32'h0);
        tick();
        chk("raw_busy_set", busy_mask, 32'h20);
        issue_rd = 8; issue_use_rs1 = 1; issue_rs1 = 5;
        #1 chk("raw_stall", {31'b0, issue_stall}, 32'h1);
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1 chk("raw_alu_ready", {31'b0, alu_ready}, 32'h1);
        tick();
        alu_valid = 0;
        chk("raw_regwrite", {31'b0, RegWrite}, 32'h1);
        chk("raw_wreg", {27'b0, WriteRegister}, 32'd5);
        chk("raw_wdata", WriteData, 32'hDEADBEEF);
        chk("raw_still_busy", busy_mask, 32'h20);
        tick();
        chk("raw_busy_clear", busy_mask, 32'h0);
        chk("raw_stall_release", {31'b0, issue_stall}, 32'h0);
        chk("raw_regwrite_drop", {31'b0, RegWrite}, 32'h0);
        issue_valid = 0; issue_use_rs1 = 0;
        $display("raw x5: written %h", WriteData);

        // ---------------- conflict / round-robin ----------------
        do_reset();
        alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h22;
        #1;
        chk("rr1_alu_ready", {31'b0, alu_ready}, 32'h1);
        chk("rr1_lsu_ready", {31'b0, lsu_ready}, 32'h0);
        tick();
        alu_rd = 5; alu_data = 32'h33;
        #1;
        chk("rr2_alu_ready", {31'b0, alu_ready}, 32'h0);
        chk("rr2_lsu_ready", {31'b0, lsu_ready}, 32'h1);
        chk("rr2_wreg", {27'b0, WriteRegister}, 32'd3);
        chk("rr2_wdata", WriteData, 32'h11);
        tick();
        lsu_rd = 6; lsu_data = 32'h44;
        #1;
        chk("rr3_alu_ready", {31'b0, alu_ready}, 32'h1);
        chk("rr3_wreg", {27'b0, WriteRegister}, 32'd4);
        chk("rr3_wdata", WriteData, 32'h22);
        tick();
        alu_valid = 0;
        #1 chk("rr4_lsu_ready", {31'b0, lsu_ready}, 32'h1);
        chk("rr4_wreg", {27'b0, WriteRegister}, 32'd5);
        tick();
        lsu_valid = 0;
        chk("rr5_wreg", {27'b0, WriteRegister}, 32'd6);
        chk("rr5_wdata", WriteData, 32'h44);
        $display("rr: order alu3 lsu4 alu5 lsu6 done");

        // ---------------- x0 ----------------
        do_reset();
        issue_valid = 1; issue_rd = 0;
        #1 chk("x0_issue_stall", {31'b0, issue_stall}, 32'h0);
        tick();
        issue_valid = 0;
        chk("x0_busy", busy_mask, 32'h0);
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hFFFFFFFF;
        #1 chk("x0_lsu_ready", {31'b0, lsu_ready}, 32'h1);
        tick();
        lsu_valid = 0;
        chk("x0_regwrite", {31'b0, RegWrite}, 32'h0);
        tick();
        chk("x0_regwrite2", {31'b0, RegWrite}, 32'h0);
        chk("x0_busy2", busy_mask, 32'h0);

        // ---------------- WAW on x7 ----------------
        do_reset();
        issue_valid = 1; issue_rd = 7;
        tick();
        #1;
        chk("waw_busy", busy_mask, 32'h80);
        chk("waw_stall", {31'b0, issue_stall}, 32'h1);
        tick();
        chk("waw_stall_hold", {31'b0, issue_stall}, 32'h1);
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        #1 chk("waw_alu_ready", {31'b0, alu_ready}, 32'h1);
        tick();
        alu_valid = 0;
        chk("waw_stall_inflight", {31'b0, issue_stall}, 32'h1);
        chk("waw_regwrite", {31'b0, RegWrite}, 32'h1);
        tick();
        chk("waw_busy_clear", busy_mask, 32'h0);
        chk("waw_stall_release", {31'b0, issue_stall}, 32'h0);
        tick();
        issue_valid = 0;
        chk("waw_busy_reset", busy_mask, 32'h80);

        // ---------------- back-to-back ----------------
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            issue_valid = 1; issue_rd = 5'(i);
            tick();
        end
        issue_valid = 0;
        chk("b2b_busy", busy_mask, 32'h1E);
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1; alu_rd = 5'(i); alu_data = 32'h100 + 32'(i);
            #1 chk($sformatf("b2b_ready[%0d]", i), {31'b0, alu_ready}, 32'h1);
            tick();
            if (i == 4) alu_valid = 0;
            chk($sformatf("b2b_regwrite[%0d]", i), {31'b0, RegWrite}, 32'h1);
            chk($sformatf("b2b_wreg[%0d]", i), {27'b0, WriteRegister}, 32'(i));
            chk($sformatf("b2b_busy[%0d]", i), busy_mask, 32'h1E & ~((32'd1 << i) - 32'd1));
            $display("b2b: wb rd=%0d data=%h", WriteRegister, WriteData);
        end
        tick();
        chk("b2b_done_regwrite", {31'b0, RegWrite}, 32'h0);
        chk("b2b_done_busy", busy_mask, 32'h0);

        // ---------------- randomized vs model ----------------
        do_reset();
        foreach (busy_m[k]) busy_m[k] = 0;
        last_lsu = 1; pv = 0; prd = 0; pdata = 0;
        a_x = 0; l_x = 0;
        for (int c = 0; c < 400; c++) begin
            if (!alu_valid || a_x) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
            end
            if (!lsu_valid || l_x) begin
                lsu_valid = 1'($urandom_range(0, 1));
                lsu_rd = 5'($urandom_range(0, 7)); lsu_data = $urandom;
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd  = 5'($urandom_range(0, 7));
            issue_rs1 = 5'($urandom_range(0, 7));
            issue_rs2 = 5'($urandom_range(0, 7));
            issue_use_rs1 = 1'($urandom_range(0, 1));
            issue_use_rs2 = 1'($urandom_range(0, 1));
            @(negedge clk);

            e_stall = issue_valid && ((issue_use_rs1 && busy_m[issue_rs1]) ||
                                      (issue_use_rs2 && busy_m[issue_rs2]) ||
                                      (issue_rd != 0 && busy_m[issue_rd]));
            e_ag = alu_valid && (!lsu_valid || last_lsu);
            e_lg = lsu_valid && !e_ag;
            e_busy = 0;
            for (int k = 0; k < 32; k++) e_busy[k] = busy_m[k];
            chk("rnd_stall", {31'b0, issue_stall}, {31'b0, e_stall});
            chk("rnd_alu_ready", {31'b0, alu_ready}, {31'b0, e_ag});
            chk("rnd_lsu_ready", {31'b0, lsu_ready}, {31'b0, e_lg});
            chk("rnd_busy", busy_mask, e_busy);
            chk("rnd_regwrite", {31'b0, RegWrite}, {31'b0, (pv && prd != 0)});
            if (pv && prd != 0) begin
                chk("rnd_wreg", {27'b0, WriteRegister}, 32'(prd));
                chk("rnd_wdata", WriteData, pdata);
                $display("rnd: wb rd=%0d data=%h", WriteRegister, WriteData);
            end

            if (pv && prd != 0) busy_m[prd] = 0;
            if (issue_valid && !e_stall && issue_rd != 0) busy_m[issue_rd] = 1;
            a_x = e_ag; l_x = e_lg;
            if (e_ag || e_lg) begin
                pv = 1;
                prd = e_ag ? int'(alu_rd) : int'(lsu_rd);
                pdata = e_ag ? alu_data : lsu_data;
                last_lsu = e_lg;
            end else begin
                pv = 0;
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
